sync_fifo: RTL and testbench
============================

// Module: sync_fifo
// PURPOSE
//  Storage side of the sync FIFO protocol: the synchronous FIFO that serves the fifo_serve
//  modport of sync_fifo_intf, one signal per port. Buffers DATA_WIDTH words between a
//  producer and a consumer in one clock domain, e.g. weight/activation staging ahead of the
//  systolic array. Standard (non-FWFT) read: data appears one cycle after an accepted read.
// PARAMETERS
//  DATA_WIDTH  16  word width; must match the sync_fifo_intf instance
//  DEPTH       8   entries; power of two, >= 2
// PORTS
//  clk        in   1                   clock, rising edge
//  rstn       in   1                   reset, synchronous, active-low
//  w_en       in   1                   write request
//  r_en       in   1                   read request
//  data_in    in   DATA_WIDTH          write data, sampled with w_en
//  data_out   out  DATA_WIDTH          read data, registered
//  full       out  1                   no free entry
//  empty      out  1                   no stored entry
//  count      out  $clog2(DEPTH)+1     current occupancy, 0..DEPTH
//  overflow   out  1                   sticky: write rejected while full
//  underflow  out  1                   sticky: read rejected while empty
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous, active-low (rstn); it is sampled on the clk edge.
//  - Reset (rstn=0 at posedge): wptr=rptr=0, data_out=0, overflow=underflow=0. The storage
//    array is not reset. After reset: empty=1, full=0, count=0.
//  - Reset mid-operation: all contents are discarded. Requests in the reset cycle are ignored.
//  - Pointers: wptr and rptr are ADDR_W+1 bits wide, where ADDR_W=$clog2(DEPTH). The low
//    ADDR_W bits index the storage. Pointers wrap modulo 2*DEPTH with natural overflow.
//  - Derived status: empty = (wptr==rptr). full = (MSBs differ and low bits equal).
//    count = wptr-rptr (unsigned, ADDR_W+1 bits). All three are combinational from registered
//    pointers only and never depend on w_en/r_en.
//  - Write acceptance: wr_ok = w_en & (~full | r_en).
//    On wr_ok: mem[wptr] <= data_in and wptr++.
//  - Read acceptance: rd_ok = r_en & ~empty.
//    On rd_ok: data_out <= mem[rptr] and rptr++. Read latency is 1 cycle.
//  - Without rd_ok, data_out holds its last value.
//  - Full and w_en&r_en together: both are accepted. count stays DEPTH, full stays 1.
//    The read takes the oldest word and the write fills the freed slot. No overflow.
//  - Empty and w_en&r_en together: only the write is accepted and the read is rejected
//    (underflow=1). Next cycle: count=1, empty=0, data_out unchanged.
//  - Non-boundary w_en&r_en: both accepted and count unchanged.
//  - overflow <= 1 when w_en & full & ~r_en.
//  - underflow <= 1 when r_en & empty.
//  - Both flags are cleared only by reset.
//  - Rejected operations change no pointer, storage or data_out state.
// STRUCTURE
//  - sync_fifo_pkg holds:
//    - function fifo_addr_w(depth) returning $clog2(depth)
//    - localparam FIFO_DEPTH_DEFAULT=8
//    - typedef fifo_status_t struct {full, empty, overflow, underflow} for monitors/scoreboards
//  - One sub-module, sync_fifo_mem: DEPTH x DATA_WIDTH array with one write port (we, waddr,
//    wdata) and one registered read port (re, raddr, rdata). rdata is reset to 0 via rstn.
//    sync_fifo keeps the pointers, flags and acceptance logic.
//  - Elaboration assertion: DEPTH is a power of two and >= 2.
// TESTING  (DATA_WIDTH=16, DEPTH=4 unless noted)
//  - Reset: hold rstn=0 for 2 cycles with w_en=1 -> empty=1, full=0, count=0, data_out=0,
//    overflow=0, underflow=0.
//  - Fill/drain: write 0x1111,0x2222,0x3333,0x4444 -> full=1, count=4. Read 4x -> data_out
//    0x1111..0x4444 each one cycle after r_en; then empty=1, underflow=0.
//  - Overflow: with full, write 0xDEAD -> overflow=1, count=4. Drain 4 words -> 0xDEAD never
//    appears.
//  - Full simultaneous: with full, w_en=r_en=1 and data_in=0x5555 -> data_out=0x1111, count=4.
//    Draining then yields 0x2222,0x3333,0x4444,0x5555.
//  - Empty simultaneous: with empty, w_en=r_en=1 and data_in=0x0A0A -> underflow=1, count=1,
//    data_out unchanged. Next read -> 0x0A0A.
//  - Wrap and mid-run reset: do 10 write/read pairs (values 0..9) -> all read in order.
//    Then write 2, pulse rstn=0 for 1 cycle -> empty=1, count=0. Next write/read returns the
//    new value only.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared definitions for the synchronous FIFO.
//   fifo_addr_w()       storage address width for a given depth
//   FIFO_DEPTH_DEFAULT  default number of entries
//   fifo_status_t       status snapshot, for monitors and scoreboards
package sync_fifo_pkg;

  localparam int FIFO_DEPTH_DEFAULT = 8;

  typedef struct packed {
    logic full;
    logic empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic int fifo_addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH x DATA_WIDTH storage with one write port and one
// registered read port.
//   clk    in   clock, rising edge
//   rstn   in   synchronous active-low reset (clears rdata only)
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable
//   raddr  in   read address
//   rdata  out  registered read data, held when re=0
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with standard (non-FWFT) read; data_out is
// valid one cycle after an accepted read.
//   clk        in   clock, rising edge
//   rstn       in   synchronous active-low reset
//   w_en       in   write request
//   r_en       in   read request
//   data_in    in   write data, sampled with w_en
//   data_out   out  registered read data
//   full       out  no free entry
//   empty      out  no stored entry
//   count      out  occupancy 0..DEPTH
//   overflow   out  sticky: write rejected while full
//   underflow  out  sticky: read rejected while empty
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = FIFO_DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         w_en,
  input  logic                         r_en,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         full,
  output logic                         empty,
  output logic [fifo_addr_w(DEPTH):0]  count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int ADDR_W = fifo_addr_w(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("sync_fifo: DEPTH must be a power of two and >= 2");
  end

  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [ADDR_W:0] rptr_q, rptr_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;
  logic            wr_ok, rd_ok;

  // Status comes from the registered pointers only. The extra pointer MSB
  // tells a full buffer apart from an empty one.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                 (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
  assign count = wptr_q - rptr_q;

  // A write into a full FIFO is accepted when a read frees the oldest slot
  // in the same cycle.
  assign wr_ok = w_en & (~full | r_en);
  assign rd_ok = r_en & ~empty;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (wr_ok) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (rd_ok) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (w_en & full & ~r_en) begin
      overflow_d = 1'b1;
    end
    if (r_en & empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // Requests during reset must not touch storage or data_out.
  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rstn  (rstn),
    .we    (wr_ok & rstn),
    .waddr (wptr_q[ADDR_W-1:0]),
    .wdata (data_in),
    .re    (rd_ok & rstn),
    .raddr (rptr_q[ADDR_W-1:0]),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          w_en = 1'b0;
  logic          r_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          full, empty, overflow, underflow;
  logic [CW-1:0] count;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a queue of stored words plus the observable registers.
  logic [DW-1:0] q_m[$];
  logic [DW-1:0] dout_m = '0;
  logic          ov_m = 1'b0;
  logic          un_m = 1'b0;

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .w_en      (w_en),
    .r_en      (r_en),
    .data_in   (data_in),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst_v, input logic w, input logic r, input logic [DW-1:0] d);
    bit was_full, was_empty;
    if (!rst_v) begin
      q_m.delete();
      dout_m = '0;
      ov_m   = 1'b0;
      un_m   = 1'b0;
    end else begin
      was_full  = (q_m.size() == DEPTH);
      was_empty = (q_m.size() == 0);
      if (w && was_full && !r) ov_m = 1'b1;
      if (r && was_empty) un_m = 1'b1;
      if (r && !was_empty) dout_m = q_m.pop_front();
      if (w && (!was_full || r)) q_m.push_back(d);
    end
  endtask

  task automatic step(input logic rst_v, input logic w, input logic r, input logic [DW-1:0] d);
    fifo_status_t obs_s, exp_s;
    rstn    = rst_v;
    w_en    = w;
    r_en    = r;
    data_in = d;
    @(posedge clk);
    model_edge(rst_v, w, r, d);
    @(negedge clk);
    obs_s = '{full: full, empty: empty, overflow: overflow, underflow: underflow};
    exp_s = '{full: (q_m.size() == DEPTH), empty: (q_m.size() == 0),
              overflow: ov_m, underflow: un_m};
    chk("status", 32'(obs_s), 32'(exp_s));
    chk("count", 32'(count), 32'(q_m.size()));
    chk("data_out", 32'(data_out), 32'(dout_m));
  endtask

  initial begin
    // Reset held two cycles with a write request present.
    step(1'b0, 1'b1, 1'b0, 16'hBEEF);
    step(1'b0, 1'b1, 1'b0, 16'hBEEF);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);

    // Fill and drain.
    step(1'b1, 1'b1, 1'b0, 16'h1111);
    step(1'b1, 1'b1, 1'b0, 16'h2222);
    step(1'b1, 1'b1, 1'b0, 16'h3333);
    step(1'b1, 1'b1, 1'b0, 16'h4444);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b0, 1'b1, '0);
      chk("drain_val", 32'(data_out), 32'(16'h1111 * i));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_underflow", 32'(underflow), 32'd0);

    // Overflow: rejected write must never come out.
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 1'b0, 16'(16'h1111 * i));
    step(1'b1, 1'b1, 1'b0, 16'hDEAD);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b0, 1'b1, '0);
      chk("ovf_drain", 32'(data_out), 32'(16'h1111 * i));
    end

    // Simultaneous read/write while full.
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 1'b0, 16'(16'h1111 * i));
    step(1'b1, 1'b1, 1'b1, 16'h5555);
    chk("fullrw_dout", 32'(data_out), 32'h1111);
    chk("fullrw_count", 32'(count), 32'd4);
    for (int i = 2; i <= 5; i++) begin
      step(1'b1, 1'b0, 1'b1, '0);
      chk("fullrw_drain", 32'(data_out), 32'(16'h1111 * i));
    end

    // Simultaneous read/write while empty.
    step(1'b1, 1'b1, 1'b1, 16'h0A0A);
    chk("emptyrw_underflow", 32'(underflow), 32'd1);
    chk("emptyrw_count", 32'(count), 32'd1);
    chk("emptyrw_dout", 32'(data_out), 32'h5555);
    step(1'b1, 1'b0, 1'b1, '0);
    chk("emptyrw_read", 32'(data_out), 32'h0A0A);

    // Pointer wrap.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'(i));
      step(1'b1, 1'b0, 1'b1, '0);
      chk("wrap_val", 32'(data_out), 32'(i));
    end

    // Mid-run reset discards contents.
    step(1'b1, 1'b1, 1'b0, 16'h00AA);
    step(1'b1, 1'b1, 1'b0, 16'h00BB);
    step(1'b0, 1'b1, 1'b1, 16'h00CC);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_count", 32'(count), 32'd0);
    step(1'b1, 1'b1, 1'b0, 16'h0077);
    step(1'b1, 1'b0, 1'b1, '0);
    chk("midrst_new", 32'(data_out), 32'h0077);
    chk("midrst_empty2", 32'(empty), 32'd1);

    // Randomized traffic against the queue model, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) != 0), 1'($urandom), 1'($urandom), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
